// File: rtl/fpu_issue_seq.sv
// Issue sequencer in front of the combinational fpu: latches one request,
// holds operands/op-select for a per-op latency, then captures the result
// and offers it to writeback on a valid/ready handshake.
module fpu_issue_seq #(
    parameter int unsigned ADD_LAT = 2,
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned DIV_LAT = 8,
    parameter int unsigned CMP_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [31:0] in_src1,
    input  logic [31:0] in_src2,
    input  logic [4:0]  in_rd,
    output logic [31:0] fpu_src1,
    output logic [31:0] fpu_src2,
    output logic [6:0]  fpu_sel,
    input  logic [31:0] fpu_result,
    input  logic        fpu_ovf,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_ovf,
    output logic [4:0]  out_rd,
    output logic        out_illegal,
    output logic        busy
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned SEL_W  = 7;
    localparam int unsigned OP_W   = 3;

    localparam int unsigned MAX_AM  = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
    localparam int unsigned MAX_DC  = (DIV_LAT > CMP_LAT) ? DIV_LAT : CMP_LAT;
    localparam int unsigned MAX_LAT = (MAX_AM > MAX_DC) ? MAX_AM : MAX_DC;
    // A zero-width counter is illegal, so keep at least one bit.
    localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [OP_W-1:0] OP_ILLEGAL = OP_W'(7);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   src1_q, src1_d;
    logic [DATA_W-1:0]   src2_q, src2_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic                ovf_q, ovf_d;
    logic [RD_W-1:0]     rd_q, rd_d;
    logic                ill_q, ill_d;
    logic                accept;

    // Hold count for each op, minus one (the capture edge is cnt==0).
    function automatic logic [CNT_W-1:0] lat_m1(input logic [OP_W-1:0] op);
        logic [CNT_W-1:0] v;
        v = '0;
        case (op)
            3'd0, 3'd1:       v = CNT_W'(ADD_LAT - 1);
            3'd2:             v = CNT_W'(MUL_LAT - 1);
            3'd3:             v = CNT_W'(DIV_LAT - 1);
            3'd4, 3'd5, 3'd6: v = CNT_W'(CMP_LAT - 1);
            default:          v = '0;
        endcase
        return v;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = (in_op == OP_ILLEGAL) ? S_DONE : S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake decode and datapath next values.
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
        accept    = in_valid && (state_q == S_IDLE);
        cnt_d     = cnt_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        sel_d     = sel_q;
        res_d     = res_q;
        ovf_d     = ovf_q;
        rd_d      = rd_q;
        ill_d     = ill_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rd_d = in_rd;
                    if (in_op == OP_ILLEGAL) begin
                        sel_d = '0;
                        res_d = '0;
                        ovf_d = 1'b0;
                        ill_d = 1'b1;
                    end else begin
                        src1_d = in_src1;
                        src2_d = in_src2;
                        sel_d  = SEL_W'(1) << in_op;
                        cnt_d  = lat_m1(in_op);
                    end
                end
            end
            S_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    res_d = fpu_result;
                    ovf_d = fpu_ovf;
                    ill_d = 1'b0;
                    sel_d = '0;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers; reset clears everything including in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            src1_q <= '0;
            src2_q <= '0;
            sel_q  <= '0;
            res_q  <= '0;
            ovf_q  <= 1'b0;
            rd_q   <= '0;
            ill_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            src1_q <= src1_d;
            src2_q <= src2_d;
            sel_q  <= sel_d;
            res_q  <= res_d;
            ovf_q  <= ovf_d;
            rd_q   <= rd_d;
            ill_q  <= ill_d;
        end
    end

    assign fpu_src1    = src1_q;
    assign fpu_src2    = src2_q;
    assign fpu_sel     = sel_q;
    assign out_result  = res_q;
    assign out_ovf     = ovf_q;
    assign out_rd      = rd_q;
    assign out_illegal = ill_q;

endmodule

// File: tb/tb_fpu_issue_seq.sv
// Directed bench for fpu_issue_seq with a table-driven stand-in fpu.
module tb_fpu_issue_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic [4:0]  in_rd;
    logic [31:0] fpu_src1;
    logic [31:0] fpu_src2;
    logic [6:0]  fpu_sel;
    logic [31:0] fpu_result;
    logic        fpu_ovf;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_ovf;
    logic [4:0]  out_rd;
    logic        out_illegal;
    logic        busy;

    int checks;
    int failures;

    fpu_issue_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_rd      (in_rd),
        .fpu_src1   (fpu_src1),
        .fpu_src2   (fpu_src2),
        .fpu_sel    (fpu_sel),
        .fpu_result (fpu_result),
        .fpu_ovf    (fpu_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_ovf    (out_ovf),
        .out_rd     (out_rd),
        .out_illegal(out_illegal),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in fpu: known answers for the directed operands, garbage otherwise.
    always_comb begin
        fpu_result = 32'hBAD0_BAD0;
        fpu_ovf    = 1'b0;
        case (fpu_sel)
            7'b0000001: if (fpu_src1 == 32'h3F80_0000 && fpu_src2 == 32'h4000_0000) fpu_result = 32'h4040_0000;
            7'b0000010: if (fpu_src1 == 32'h4040_0000 && fpu_src2 == 32'h3F80_0000) fpu_result = 32'h4000_0000;
            7'b0000100: begin
                if (fpu_src1 == 32'h4000_0000 && fpu_src2 == 32'h4040_0000) fpu_result = 32'h40C0_0000;
                if (fpu_src1 == 32'h7F00_0000 && fpu_src2 == 32'h7F00_0000) begin
                    fpu_result = 32'h7F80_0000;
                    fpu_ovf    = 1'b1;
                end
            end
            7'b0001000: if (fpu_src1 == 32'h40C0_0000 && fpu_src2 == 32'h4000_0000) fpu_result = 32'h4040_0000;
            7'b0010000: fpu_result = (fpu_src1 == fpu_src2) ? 32'd1 : 32'd0;
            7'b0100000: begin
                if (fpu_src1 == 32'h3F80_0000 && fpu_src2 == 32'h4000_0000) fpu_result = 32'd1;
                if (fpu_src1 == 32'h4000_0000 && fpu_src2 == 32'h3F80_0000) fpu_result = 32'd0;
            end
            7'b1000000: begin
                if (fpu_src1 == 32'h3F80_0000 && fpu_src2 == 32'h4000_0000) fpu_result = 32'd1;
                if (fpu_src1 == 32'h4000_0000 && fpu_src2 == 32'h3F80_0000) fpu_result = 32'd0;
            end
            default: begin
            end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, check the EXEC window, DONE contents, backpressure and release.
    task automatic run_op(input logic [2:0] op, input logic [31:0] s1, input logic [31:0] s2,
                          input logic [4:0] rd, input int lat, input logic [31:0] exp_res,
                          input logic exp_ovf, input int hold);
        logic [6:0]  exp_sel;
        logic [31:0] prev_s1;
        logic [31:0] prev_s2;
        logic        exp_ill;
        exp_ill = (op == 3'd7);
        exp_sel = '0;
        if (!exp_ill) exp_sel[op] = 1'b1;
        prev_s1 = fpu_src1;
        prev_s2 = fpu_src2;
        check("in_ready_before", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_src1  = s1;
        in_src2  = s2;
        in_rd    = rd;
        step();
        // Requests during EXEC/DONE must be ignored.
        in_op   = 3'd3;
        in_src1 = 32'hFFFF_FFFF;
        in_src2 = 32'h1234_5678;
        in_rd   = 5'd31;
        for (int i = 0; i < lat; i++) begin
            check("exec_sel", 32'(fpu_sel), 32'(exp_sel));
            check("exec_src1", fpu_src1, s1);
            check("exec_src2", fpu_src2, s2);
            check("exec_out_valid", 32'(out_valid), 32'd0);
            check("exec_in_ready", 32'(in_ready), 32'd0);
            check("exec_busy", 32'(busy), 32'd1);
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i <= hold; i++) begin
            check("done_out_valid", 32'(out_valid), 32'd1);
            check("done_result", out_result, exp_res);
            check("done_ovf", 32'(out_ovf), 32'(exp_ovf));
            check("done_rd", 32'(out_rd), 32'(rd));
            check("done_illegal", 32'(out_illegal), 32'(exp_ill));
            check("done_sel", 32'(fpu_sel), 32'd0);
            check("done_in_ready", 32'(in_ready), 32'd0);
            check("done_src1", fpu_src1, exp_ill ? prev_s1 : s1);
            check("done_src2", fpu_src2, exp_ill ? prev_s2 : s2);
            if (i == hold) out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        check("after_out_valid", 32'(out_valid), 32'd0);
        check("after_in_ready", 32'(in_ready), 32'd1);
        check("after_busy", 32'(busy), 32'd0);
    endtask

    int seen_valid;

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_src1   = '0;
        in_src2   = '0;
        in_rd     = '0;
        out_ready = 1'b0;
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sel", 32'(fpu_sel), 32'd0);
        check("rst_result", out_result, 32'd0);
        rst = 1'b0;
        step();

        run_op(3'd0, 32'h3F80_0000, 32'h4000_0000, 5'd3,  2, 32'h4040_0000, 1'b0, 0);
        run_op(3'd3, 32'h40C0_0000, 32'h4000_0000, 5'd7,  8, 32'h4040_0000, 1'b0, 0);
        run_op(3'd5, 32'h3F80_0000, 32'h4000_0000, 5'd9,  1, 32'h0000_0001, 1'b0, 0);
        run_op(3'd6, 32'h4000_0000, 32'h3F80_0000, 5'd10, 1, 32'h0000_0000, 1'b0, 0);
        run_op(3'd2, 32'h4000_0000, 32'h4040_0000, 5'd11, 2, 32'h40C0_0000, 1'b0, 5);
        run_op(3'd7, 32'hAAAA_AAAA, 32'h5555_5555, 5'd12, 0, 32'h0000_0000, 1'b0, 0);
        run_op(3'd0, 32'h3F80_0000, 32'h4000_0000, 5'd13, 2, 32'h4040_0000, 1'b0, 0);
        run_op(3'd1, 32'h4040_0000, 32'h3F80_0000, 5'd14, 2, 32'h4000_0000, 1'b0, 0);
        run_op(3'd2, 32'h7F00_0000, 32'h7F00_0000, 5'd15, 2, 32'h7F80_0000, 1'b1, 1);
        run_op(3'd4, 32'h3F80_0000, 32'h3F80_0000, 5'd16, 1, 32'h0000_0001, 1'b0, 0);

        // Reset three cycles into an fdiv drops it.
        in_valid = 1'b1;
        in_op    = 3'd3;
        in_src1  = 32'h40C0_0000;
        in_src2  = 32'h4000_0000;
        in_rd    = 5'd20;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        check("mid_busy", 32'(busy), 32'd1);
        rst       = 1'b1;
        out_ready = 1'b1;
        step();
        rst       = 1'b0;
        out_ready = 1'b0;
        check("rst2_out_valid", 32'(out_valid), 32'd0);
        check("rst2_busy", 32'(busy), 32'd0);
        check("rst2_in_ready", 32'(in_ready), 32'd1);
        check("rst2_src1", fpu_src1, 32'd0);
        check("rst2_src2", fpu_src2, 32'd0);
        check("rst2_sel", 32'(fpu_sel), 32'd0);
        check("rst2_result", out_result, 32'd0);
        check("rst2_rd", 32'(out_rd), 32'd0);
        check("rst2_ovf_ill", 32'({out_ovf, out_illegal}), 32'd0);
        seen_valid = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) seen_valid++;
            step();
        end
        check("dropped_no_valid", 32'(seen_valid), 32'd0);
        run_op(3'd0, 32'h3F80_0000, 32'h4000_0000, 5'd21, 2, 32'h4040_0000, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
